// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: valid/ready pipeline-register chain with stall, flush and
// a saturating flushed-entry counter.
// Ports: clk, reset (async, active-low); in_valid/in_ready/in_data upstream;
//   out_valid/out_ready/out_data downstream; flush kills in-flight entries;
//   count = entries held; kill_cnt = saturating count of flushed entries.
// Option: define PIPE_CHAIN_SKID_EN to add a skid entry ahead of stage 0,
//   making in_ready a registered signal and raising capacity to STAGES+1.
module pipe_stage_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int KILL_W = 16,
    localparam int CW    = $clog2(STAGES + 2)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    input  logic              flush,
    output logic [CW-1:0]     count,
    output logic [KILL_W-1:0] kill_cnt
);

    localparam int SW = ((KILL_W > CW) ? KILL_W : CW) + 1;
    localparam logic [KILL_W-1:0] KMAX = '1;

    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [STAGES:0]   r;
    logic              in_xfer;
    logic              out_xfer;
    logic              src_v;
    logic [WIDTH-1:0]  src_d;
    logic [CW-1:0]     count_q, count_d;
    logic [KILL_W-1:0] kill_q, kill_d;
    logic [SW-1:0]     kill_sum;

    // r[i]: stage i may load this edge. Built with a running OR so each
    // bit depends only on v_q and out_ready, never on another r bit.
    always_comb begin : ready_chain
        logic acc;
        acc       = out_ready;
        r         = '0;
        r[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc  = acc | ~v_q[i];
            r[i] = acc;
        end
    end

    assign in_xfer   = in_valid & in_ready;
    assign out_valid = v_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
    assign out_xfer  = out_valid & out_ready;

`ifdef PIPE_CHAIN_SKID_EN
    logic             skid_v_q;
    logic [WIDTH-1:0] skid_d_q;

    // Registered ready: no combinational path from out_ready.
    assign in_ready = reset & ~skid_v_q;
    // The skid entry is older than any new beat, so it loads first.
    assign src_v    = skid_v_q | in_xfer;
    assign src_d    = skid_v_q ? skid_d_q : in_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_v_q <= 1'b0;
            skid_d_q <= '0;
        end else begin
            if (skid_v_q) begin
                if (r[0]) skid_v_q <= 1'b0;
            end else if (in_xfer && !r[0]) begin
                skid_v_q <= 1'b1;
                skid_d_q <= in_data;
            end
            if (flush) skid_v_q <= 1'b0;
        end
    end
`else
    assign in_ready = reset & r[0];
    assign src_v    = in_xfer;
    assign src_d    = in_data;
`endif

    // Flush discards what stays behind; a same-edge output beat still leaves.
    always_comb begin
        count_d  = count_q + CW'(in_xfer) - CW'(out_xfer);
        kill_sum = SW'(kill_q) + SW'(count_q) - SW'(out_xfer);
        kill_d   = kill_q;
        if (flush) begin
            count_d = '0;
            if (kill_sum > {{(SW-KILL_W){1'b0}}, KMAX}) kill_d = KMAX;
            else                                        kill_d = kill_sum[KILL_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q     <= '0;
            for (int i = 0; i < STAGES; i++) d_q[i] <= '0;
            count_q <= '0;
            kill_q  <= '0;
        end else begin
            for (int i = STAGES - 1; i >= 1; i--) begin
                if (r[i]) begin
                    v_q[i] <= v_q[i-1];
                    if (v_q[i-1]) d_q[i] <= d_q[i-1];
                end
            end
            if (r[0]) begin
                v_q[0] <= src_v;
                if (src_v) d_q[0] <= src_d;
            end
            if (flush) v_q <= '0;
            count_q <= count_d;
            kill_q  <= kill_d;
        end
    end

    assign count    = count_q;
    assign kill_cnt = kill_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: scoreboard bench for pipe_stage_chain.
// Queue model of in-flight beats; monitor pops on output handshakes.
module tb_pipe_stage_chain;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int KILL_W = 4;
    localparam int CW     = $clog2(STAGES + 2);
`ifdef PIPE_CHAIN_SKID_EN
    localparam int CAP = STAGES + 1;
`else
    localparam int CAP = STAGES;
`endif
    localparam int KMAX = (1 << KILL_W) - 1;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              flush;
    logic [CW-1:0]     count;
    logic [KILL_W-1:0] kill_cnt;

    int checks    = 0;
    int errors    = 0;
    int delivered = 0;
    int kill_exp  = 0;
    logic [WIDTH-1:0] q[$];
    bit ov_s;
    int cnt_s;
    int kill_s;

    pipe_stage_chain #(
        .WIDTH (WIDTH),
        .STAGES(STAGES),
        .KILL_W(KILL_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .flush    (flush),
        .count    (count),
        .kill_cnt (kill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input longint act,
                                input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // One cycle: check post-edge state, drive inputs, update the model.
    task automatic step(input bit iv, input logic [WIDTH-1:0] idat,
                        input bit ordy, input bit fl, output bit acc);
        @(negedge clk);
        ov_s   = out_valid;
        cnt_s  = int'(count);
        kill_s = int'(kill_cnt);
        chk("count", count, q.size());
        chk("kill_cnt", kill_cnt, kill_exp);
        in_valid  = iv;
        in_data   = idat;
        out_ready = ordy;
        flush     = fl;
        #1;
        if (q.size() == 0) chk("in_ready_empty", in_ready, 1);
        if (q.size() == CAP && !ordy) chk("in_ready_full", in_ready, 0);
        acc = iv && in_ready;
        if (acc && !fl) q.push_back(idat);
        #2;
        if (fl) begin
            kill_exp = kill_exp + q.size();
            if (kill_exp > KMAX) kill_exp = KMAX;
            q.delete();
        end
    endtask

    // Monitor: runs after the driver has settled inputs for the cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("out_valid_unexpected", out_valid, 0);
                end else begin
                    chk("out_data", out_data, q[0]);
                    if (out_ready) begin
                        void'(q.pop_front());
                        delivered++;
                    end
                end
            end
        end
    end

    task automatic latency_check(input logic [WIDTH-1:0] d);
        bit a;
        int n;
        step(1, d, 1, 0, a);
        chk("lat_accept", a, 1);
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            step(0, '0, 1, 0, a);
            if (ov_s) begin
                n = k;
                break;
            end
        end
        chk("latency_edges", n, STAGES);
        repeat (STAGES + 1) step(0, '0, 1, 0, a);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        in_valid  = 0;
        out_ready = 0;
        flush     = 0;
        #4;
        reset = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_kill_cnt", kill_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data", out_data, 0);
        q.delete();
        kill_exp = 0;
        @(negedge clk);
        #1;
        chk("rst_hold_valid", out_valid, 0);
        reset = 1;
        #1;
        chk("rst_release_ready", in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit a;
        int nacc;
        int d0;
        logic [WIDTH-1:0] nxt;

        reset     = 0;
        in_valid  = 0;
        in_data   = '0;
        out_ready = 0;
        flush     = 0;
        #1;
        chk("init_in_ready", in_ready, 0);
        chk("init_out_valid", out_valid, 0);
        chk("init_out_data", out_data, 0);
        chk("init_count", count, 0);
        chk("init_kill", kill_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        #1;
        chk("init_release_ready", in_ready, 1);

        latency_check(32'h5A);

        // Back-to-back stream
        step(1, 32'h11, 1, 0, a);
        step(1, 32'h22, 1, 0, a);
        step(1, 32'h33, 1, 0, a);
        chk("stream_cnt_e2", cnt_s, 2);
        chk("stream_ov_e2", ov_s, 1);
        step(0, '0, 1, 0, a);
        chk("stream_cnt_e3", cnt_s, 2);
        chk("stream_ov_e3", ov_s, 1);
        step(0, '0, 1, 0, a);
        chk("stream_ov_e4", ov_s, 1);
        repeat (3) step(0, '0, 1, 0, a);

        // Backpressure
        nxt  = 32'h100;
        nacc = 0;
        for (int k = 0; k < 6; k++) begin
            step(1, nxt, 0, 0, a);
            if (a) begin
                nxt++;
                nacc++;
            end
        end
        chk("bp_accepted", nacc, CAP);
        chk("bp_hold_data", out_data, 32'h100);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_in_ready", in_ready, 0);
        d0 = delivered;
        repeat (8) step(0, '0, 1, 0, a);
        chk("bp_delivered", delivered - d0, CAP);
        chk("bp_drained_count", count, 0);

        // Flush with two held entries, no output
        step(1, 32'hA1, 0, 0, a);
        step(1, 32'hA2, 0, 0, a);
        step(0, '0, 0, 1, a);
        step(0, '0, 0, 0, a);
        chk("flushA_kill", kill_s, 2);
        chk("flushA_count", cnt_s, 0);
        chk("flushA_ovalid", ov_s, 0);

        // Flush alongside output and input handshakes
        d0 = delivered;
        step(1, 32'hB1, 0, 0, a);
        step(1, 32'hB2, 0, 0, a);
        step(1, 32'hAA, 1, 1, a);
        chk("flushB_in_acc", a, 1);
        step(0, '0, 0, 0, a);
        chk("flushB_kill", kill_s, 3);
        chk("flushB_count", cnt_s, 0);
        chk("flushB_ovalid", ov_s, 0);
        chk("flushB_delivered", delivered - d0, 1);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, a);
        end
        repeat (10) step(0, '0, 1, 0, a);

        // Reset in the middle of a stream
        repeat (3) step(1, $urandom, 1, 0, a);
        mid_reset();
        latency_check(32'h77);

        // Saturation of kill_cnt
        for (int f = 0; f < 10; f++) begin
            step(1, $urandom, 0, 0, a);
            step(1, $urandom, 0, 0, a);
            step(0, '0, 0, 1, a);
        end
        step(0, '0, 0, 0, a);
        chk("sat_kill", kill_s, KMAX);
        step(1, $urandom, 0, 0, a);
        step(1, $urandom, 0, 0, a);
        step(0, '0, 0, 1, a);
        step(0, '0, 0, 0, a);
        chk("sat_hold", kill_s, KMAX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
